reg_file_sb: RTL
================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1, where 1 hardwires register 0 to zero.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  write strobe for the result/retire port.
REQ-007 SHALL have port wr_addr  input  ADDR_W  write target register.
REQ-008 SHALL have port wr_data  input  DATA_W  write data.
REQ-009 SHALL have port rd_addr_a  input  ADDR_W  read port A address.
REQ-010 SHALL have port rd_addr_b  input  ADDR_W  read port B address.
REQ-011 SHALL have port rd_data_a  output  DATA_W  registered read data for port A.
REQ-012 SHALL have port rd_data_b  output  DATA_W  registered read data for port B.
REQ-013 SHALL have port rd_busy_a  output  1  registered pending-write flag for rd_addr_a.
REQ-014 SHALL have port rd_busy_b  output  1  registered pending-write flag for rd_addr_b.
REQ-015 SHALL have port issue_en  input  1  decode requests to reserve a destination register.
REQ-016 SHALL have port issue_addr  input  ADDR_W  destination register to reserve.
REQ-017 SHALL have port issue_stall  output  1  combinational; issue refused this cycle.

Function
REQ-018 SHALL store 2**ADDR_W registers of DATA_W bits plus one busy bit per register.
REQ-019 SHALL write wr_data to wr_addr and clear busy[wr_addr] on each rising clk edge with wr_en=1.
REQ-020 SHALL ignore writes to address 0 and keep busy[0]=0 when ZERO_REG=1.
REQ-021 SHALL present read data one cycle after the address: rd_data_x(t+1) = reg[rd_addr_x(t)].
REQ-022 SHALL bypass: when wr_en=1 and wr_addr equals rd_addr_x in the same cycle, rd_data_x on the next cycle SHALL equal wr_data (write-first), except address 0 with ZERO_REG=1, which returns 0.
REQ-023 SHALL register rd_busy_x as the busy state after that edge's updates have been applied.
REQ-024 SHALL drive issue_stall = issue_en & busy[issue_addr] & ~(wr_en & wr_addr==issue_addr).
REQ-025 SHALL set busy[issue_addr] on an edge with issue_en=1 and issue_stall=0; a stalled issue SHALL change no state.
REQ-026 SHALL give set priority when issue and write target the same address in the same cycle: data is written and busy ends at 1.
REQ-027 SHALL never stall an issue to address 0 when ZERO_REG=1, and that issue SHALL change no state.
REQ-028 SHALL allow both read ports to address the same register simultaneously, returning identical data.

Reset
REQ-029 SHALL on reset=1, regardless of clk, clear all registers, all busy bits, rd_data_a, rd_data_b, rd_busy_a and rd_busy_b to 0.
REQ-030 SHALL ignore wr_en and issue_en while reset=1; reset mid-operation SHALL discard all pending reservations.

Verification
REQ-031 Write then read: wr 0xDEADBEEF to r3, next cycle rd_addr_a=3 -> rd_data_a=0xDEADBEEF one cycle later, rd_busy_a=0.
REQ-032 Bypass: wr_en=1, wr_addr=7, wr_data=0x55, rd_addr_b=7 in the same cycle -> rd_data_b=0x55 next cycle.
REQ-033 Zero register: wr 0xFFFFFFFF to r0 and issue r0 -> rd_data_a(r0)=0, rd_busy_a=0, issue_stall=0.
REQ-034 Scoreboard: issue r5 -> rd_busy for r5 = 1; re-issue r5 -> issue_stall=1; write r5 -> busy clears; issue r5 plus write r5 in the same cycle -> no stall, busy=1, data updated.
REQ-035 Async reset: after loading r1..r31 and reserving r9, assert reset between clock edges -> all outputs 0 immediately, and every read returns 0 after release.
REQ-036 Parameter sweep: DATA_W=16, ADDR_W=3, ZERO_REG=0 -> r0 is writable, all 8 registers hold independent values, and widths match.

Source files
------------

// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard: one write/retire port, two
// registered read ports with write-first bypass, and an issue port that reserves destinations.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_stall
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic              wr_ok;
    logic              issue_ok;

    // A retiring write to the same register releases it in time for the new issue.
    assign issue_stall = issue_en && busy[issue_addr] && !(wr_en && (wr_addr == issue_addr));

    always_comb begin
        wr_ok     = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
        issue_ok  = issue_en && !issue_stall && !((ZERO_REG != 0) && (issue_addr == '0));
        busy_next = busy;
        if (wr_ok) begin
            busy_next[wr_addr] = 1'b0;
        end
        // Set after clear: a same-cycle issue keeps the register reserved.
        if (issue_ok) begin
            busy_next[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy      <= '0;
            rd_data_a <= '0;
            rd_data_b <= '0;
            rd_busy_a <= 1'b0;
            rd_busy_b <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs[wr_addr] <= wr_data;
            end
            busy      <= busy_next;
            rd_data_a <= (wr_ok && (wr_addr == rd_addr_a)) ? wr_data : regs[rd_addr_a];
            rd_data_b <= (wr_ok && (wr_addr == rd_addr_b)) ? wr_data : regs[rd_addr_b];
            rd_busy_a <= busy_next[rd_addr_a];
            rd_busy_b <= busy_next[rd_addr_b];
        end
    end
endmodule
